// File: rtl/seq_divider_if.sv
// ---------------------------------------------------------------------------
// seq_divider_if
//   Operand/result handshake bundle for seq_divider.
//   N           : divisor/remainder width; dividend/quotient are 2N bits.
//   in_valid    : operands present            (master -> slave)
//   in_ready    : divider can accept operands (slave  -> master)
//   dividend    : 2N-bit unsigned dividend    (master -> slave)
//   divisor     : N-bit unsigned divisor      (master -> slave)
//   out_valid   : result present              (slave  -> master)
//   out_ready   : consumer accepts result     (master -> slave)
//   quotient    : 2N-bit unsigned quotient    (slave  -> master)
//   remainder   : N-bit unsigned remainder    (slave  -> master)
//   div_by_zero : result came from divisor==0 (slave  -> master)
// ---------------------------------------------------------------------------
interface seq_divider_if #(
    parameter int N = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2*N-1:0]   dividend;
    logic [N-1:0]     divisor;
    logic             out_valid;
    logic             out_ready;
    logic [2*N-1:0]   quotient;
    logic [N-1:0]     remainder;
    logic             div_by_zero;

    // Divider side
    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );

    // Operand producer / result consumer side
    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
//   Sequential restoring unsigned divider, one quotient bit per clock.
//   Divides a 2N-bit dividend by an N-bit divisor giving a 2N-bit quotient
//   and an N-bit remainder. Result valid 2N cycles after acceptance
//   (1 cycle for a zero divisor).
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : seq_divider_if.slave (operand and result valid/ready handshakes)
// ---------------------------------------------------------------------------
module seq_divider #(
    parameter int N = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_divider_if.slave  bus
);
    localparam int W  = 2 * N;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    // Shared shift register: dividend bits leave at the MSB while quotient
    // bits enter at the LSB, so after 2N steps it holds the full quotient.
    logic [W-1:0]    shreg_q, shreg_d;
    logic [N-1:0]    divisor_q, divisor_d;
    logic [N-1:0]    rem_q, rem_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            zero_q, zero_d;
    logic [W-1:0]    quotient_q, quotient_d;
    logic [N-1:0]    remainder_q, remainder_d;
    logic            dbz_q, dbz_d;

    logic [N:0]      trial;
    logic [N-1:0]    diff;
    logic            take;
    logic [N-1:0]    step_rem;
    logic [W-1:0]    step_shreg;

    // Trial value is N+1 bits; when it is >= divisor the true difference is
    // below the divisor, so an N-bit modular subtract yields it exactly.
    assign trial      = {rem_q, shreg_q[W-1]};
    assign take       = (trial >= {1'b0, divisor_q});
    assign diff       = trial[N-1:0] - divisor_q;
    assign step_rem   = take ? diff : trial[N-1:0];
    assign step_shreg = {shreg_q[W-2:0], take};

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        divisor_d   = divisor_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        zero_d      = zero_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    shreg_d   = bus.dividend;
                    divisor_d = bus.divisor;
                    state_d   = CALC;
                    if (bus.divisor == '0) begin
                        // Zero divisor spends a single cycle in CALC so
                        // its result appears one cycle after acceptance.
                        zero_d = 1'b1;
                        cnt_d  = CW'(1);
                    end else begin
                        zero_d = 1'b0;
                        rem_d  = '0;
                        dbz_d  = 1'b0;
                        cnt_d  = CW'(W);
                    end
                end
            end

            CALC: begin
                if (zero_q) begin
                    quotient_d  = '1;
                    remainder_d = shreg_q[N-1:0];
                    dbz_d       = 1'b1;
                    cnt_d       = '0;
                    state_d     = DONE;
                end else begin
                    rem_d   = step_rem;
                    shreg_d = step_shreg;
                    cnt_d   = cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        quotient_d  = step_shreg;
                        remainder_d = step_rem;
                        dbz_d       = 1'b0;
                        state_d     = DONE;
                    end
                end
            end

            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            divisor_q   <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            zero_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            divisor_q   <= divisor_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            zero_q      <= zero_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = (state_q == DONE);
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_divider
//   Directed and random self-checking bench for seq_divider (N=8).
//   Prints one line per completed transaction and a final summary line.
// ---------------------------------------------------------------------------
module tb_seq_divider;
    localparam int N = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    seq_divider_if #(.N(N)) bus ();

    seq_divider #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // mode: 0 = out_ready low while busy, 1 = out_ready high throughout,
    //       2 = out_ready random while busy.
    // stall: cycles to hold out_ready low after out_valid is seen.
    // hold_iv: keep in_valid high (with fresh operands) after acceptance.
    task automatic run_op(input logic [15:0] dvd, input logic [7:0] dvs,
                          input logic [15:0] exp_q, input logic [7:0] exp_r,
                          input logic exp_dbz, input int exp_lat,
                          input int mode, input int stall, input logic hold_iv,
                          output logic [15:0] q_obs, output logic [7:0] r_obs);
        int lat;
        check_val("in_ready_idle", bus.in_ready, 1);
        bus.dividend  = dvd;
        bus.divisor   = dvs;
        bus.in_valid  = 1'b1;
        bus.out_ready = (mode == 1);
        tick;
        bus.in_valid = hold_iv;
        bus.dividend = 16'($urandom);
        bus.divisor  = 8'($urandom);
        check_val("in_ready_busy", bus.in_ready, 0);
        lat = 0;
        while (!bus.out_valid && lat < 64) begin
            if (mode == 2) bus.out_ready = 1'($urandom_range(0, 1));
            tick;
            lat++;
        end
        check_val("latency", lat, exp_lat);
        check_val("quotient", bus.quotient, exp_q);
        check_val("remainder", bus.remainder, exp_r);
        check_val("div_by_zero", bus.div_by_zero, exp_dbz);
        q_obs = bus.quotient;
        r_obs = bus.remainder;
        bus.out_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            tick;
            check_val("hold_valid", bus.out_valid, 1);
            check_val("hold_quotient", bus.quotient, exp_q);
            check_val("hold_remainder", bus.remainder, exp_r);
            check_val("hold_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        tick;
        check_val("done_out_valid", bus.out_valid, 0);
        check_val("done_in_ready", bus.in_ready, 1);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        $display("txn %0d/%0d -> q=%0d r=%0d dbz=%0d lat=%0d",
                 dvd, dvs, q_obs, r_obs, exp_dbz, lat);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] q_obs;
        logic [7:0]  r_obs;
        logic [15:0] dvd;
        logic [7:0]  dvs;
        int          stale;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_in_ready", bus.in_ready, 1);
        check_val("rst_out_valid", bus.out_valid, 0);
        check_val("rst_quotient", bus.quotient, 0);
        check_val("rst_remainder", bus.remainder, 0);
        check_val("rst_div_by_zero", bus.div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick;

        // Directed vectors (hand-computed)
        run_op(16'd1000,  8'd7,   16'd142,   8'd6,   1'b0, 16, 1, 0, 1'b0, q_obs, r_obs);
        run_op(16'd65535, 8'd1,   16'd65535, 8'd0,   1'b0, 16, 0, 0, 1'b0, q_obs, r_obs);
        run_op(16'd65535, 8'd255, 16'd257,   8'd0,   1'b0, 16, 0, 1, 1'b0, q_obs, r_obs);
        run_op(16'd5,     8'd9,   16'd0,     8'd5,   1'b0, 16, 0, 0, 1'b0, q_obs, r_obs);
        run_op(16'd0,     8'd3,   16'd0,     8'd0,   1'b0, 16, 0, 0, 1'b0, q_obs, r_obs);
        run_op(16'd65534, 8'd255, 16'd256,   8'd254, 1'b0, 16, 0, 2, 1'b0, q_obs, r_obs);
        run_op(16'd1234,  8'd0,   16'hFFFF,  8'hD2,  1'b1, 1,  0, 0, 1'b0, q_obs, r_obs);
        run_op(16'd10,    8'd3,   16'd3,     8'd1,   1'b0, 16, 0, 0, 1'b0, q_obs, r_obs);

        // Backpressure: 20 stalled cycles with in_valid held high
        run_op(16'd50000, 8'd99,  16'd505,   8'd5,   1'b0, 16, 0, 20, 1'b1, q_obs, r_obs);

        // Reset at CALC step 8 of 40000/200, between clock edges
        bus.dividend = 16'd40000;
        bus.divisor  = 8'd200;
        bus.in_valid = 1'b1;
        tick;
        bus.in_valid = 1'b0;
        repeat (8) tick;
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_out_valid", bus.out_valid, 0);
        check_val("mid_rst_in_ready", bus.in_ready, 1);
        check_val("mid_rst_quotient", bus.quotient, 0);
        check_val("mid_rst_remainder", bus.remainder, 0);
        check_val("mid_rst_div_by_zero", bus.div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        repeat (24) begin
            tick;
            if (bus.out_valid) stale++;
        end
        check_val("no_stale_result", stale, 0);
        run_op(16'd40000, 8'd200, 16'd200, 8'd0, 1'b0, 16, 0, 0, 1'b0, q_obs, r_obs);

        // Random operands with random out_ready
        for (int k = 0; k < 2000; k++) begin
            dvd = 16'($urandom);
            dvs = 8'($urandom);
            if (dvs == 8'd0) begin
                run_op(dvd, dvs, 16'hFFFF, dvd[7:0], 1'b1, 1, 2,
                       $urandom_range(0, 3), 1'b0, q_obs, r_obs);
            end else begin
                run_op(dvd, dvs, dvd / 16'(dvs), 8'(dvd % 16'(dvs)), 1'b0, 16, 2,
                       $urandom_range(0, 3), 1'b0, q_obs, r_obs);
                check_val("invariant", 32'(q_obs) * 32'(dvs) + 32'(r_obs), 32'(dvd));
                check_val("rem_lt_divisor", 32'(r_obs < dvs), 1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
